// File: rtl/seq_shifter.sv
// Sequential 32-bit shifter (SLL/SRL/ROTR/SRA) stepping one position per cycle.
// Optional macro SEQ_SHIFTER_FAST4_EN enables 4-position steps while Count>=4.
`timescale 1ns/1ps

module seq_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_ROTR = 2'b10;

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic [4:0]  count;
    logic [31:0] work;
    logic [31:0] work_next;
    logic [4:0]  count_next;

    function automatic logic [31:0] step(input logic [31:0] v, input logic [1:0] o,
                                         input logic [2:0] amt);
        logic [31:0] r;
        case (o)
            OP_SLL:  r = v << amt;
            OP_SRL:  r = v >> amt;
            OP_ROTR: r = (v >> amt) | (v << (6'd32 - {3'd0, amt}));
            default: r = $signed(v) >>> amt;
        endcase
        return r;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        work_next  = step(work, op_q, 3'd1);
        count_next = count - 5'd1;
`ifdef SEQ_SHIFTER_FAST4_EN
        if (count >= 5'd4) begin
            work_next  = step(work, op_q, 3'd4);
            count_next = count - 5'd4;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= OP_SLL;
            count <= 5'd0;
            work  <= 32'd0;
            out   <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work  <= in;
                        op_q  <= op;
                        count <= shamt;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // count_next is only used while count is nonzero, so Count never wraps.
                    if (count != 5'd0) begin
                        work  <= work_next;
                        count <= count_next;
                    end else begin
                        out   <= work;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
